// File: rtl/pixel_write_sequencer.sv
// Pixel write sequencer: turns broker pixel strobes into addressed framebuffer
// writes through a small FIFO, with a wrapping write cursor that the MCU can
// reposition using a three-byte SET_CURSOR command or a HOME command.
module pixel_write_sequencer #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     system_clock,
  input  logic                     reset_n,
  input  logic                     pixel_strobe,
  input  logic [DATA_WIDTH-1:0]    pixel_data,
  input  logic                     command_strobe,
  input  logic [7:0]               command_byte,
  output logic                     write_valid,
  input  logic                     write_ready,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     frame_done,
  output logic                     overflow,
  output logic                     cursor_error,
  output logic [ADDRESS_WIDTH-1:0] cursor
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] FRAME_PIXELS = 32'(WIDTH * HEIGHT);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(WIDTH * HEIGHT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [7:0] OP_SET_CURSOR = 8'h05;
  localparam logic [7:0] OP_HOME       = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    ARG0,
    ARG1,
    ARG2
  } cmd_state_e;

  cmd_state_e state_q, state_d;
  logic [7:0] argLow_q, argLow_d;
  logic [7:0] argMid_q, argMid_d;

  logic [ADDRESS_WIDTH-1:0] cursor_q, cursor_d;
  logic                     frameDone_q, frameDone_d;
  logic                     overflow_q, overflow_d;
  logic                     cursorError_q, cursorError_d;

  logic [ADDRESS_WIDTH-1:0] addrMem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    dataMem_q [FIFO_DEPTH];
  logic [PTR_W:0]           wrPtr_q, wrPtr_d;
  logic [PTR_W:0]           rdPtr_q, rdPtr_d;

  logic [PTR_W:0]           fifoCount;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     fifoPush;
  logic                     fifoPop;

  logic                     cmdLoad;
  logic                     cmdReject;
  logic [ADDRESS_WIDTH-1:0] cmdValue;
  logic [23:0]              argFull;

  // FIFO occupancy and the push/pop decisions; a full FIFO still accepts a
  // pixel when the head leaves in the same cycle.
  always_comb begin
    fifoCount = wrPtr_q - rdPtr_q;
    fifoFull  = (fifoCount == DEPTH_COUNT);
    fifoEmpty = (fifoCount == '0);
    fifoPop   = !fifoEmpty && write_ready;
    fifoPush  = pixel_strobe && (!fifoFull || fifoPop);
  end

  // Command decoder: collects the three SET_CURSOR argument bytes and decides
  // whether a cursor load (or a rejected load) happens this cycle.
  always_comb begin
    state_d   = state_q;
    argLow_d  = argLow_q;
    argMid_d  = argMid_q;
    cmdLoad   = 1'b0;
    cmdReject = 1'b0;
    cmdValue  = '0;
    argFull   = {command_byte, argMid_q, argLow_q};
    if (command_strobe) begin
      case (state_q)
        IDLE: begin
          if (command_byte == OP_SET_CURSOR) begin
            state_d = ARG0;
          end else if (command_byte == OP_HOME) begin
            cmdLoad  = 1'b1;
            cmdValue = '0;
          end
        end
        ARG0: begin
          argLow_d = command_byte;
          state_d  = ARG1;
        end
        ARG1: begin
          argMid_d = command_byte;
          state_d  = ARG2;
        end
        ARG2: begin
          state_d = IDLE;
          if ({8'd0, argFull} < FRAME_PIXELS) begin
            cmdLoad  = 1'b1;
            cmdValue = ADDRESS_WIDTH'(argFull);
          end else begin
            cmdReject = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Cursor, pointer and flag next-state; a command load overrides the
  // increment, and frame_done only marks a wrap caused by the increment.
  always_comb begin
    cursor_d      = cursor_q;
    frameDone_d   = 1'b0;
    overflow_d    = overflow_q;
    cursorError_d = cursorError_q;
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    if (fifoPush) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
      if (cursor_q == LAST_ADDR) begin
        cursor_d    = '0;
        frameDone_d = !cmdLoad;
      end else begin
        cursor_d = cursor_q + ADDR_ONE;
      end
    end
    if (fifoPop) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (pixel_strobe && !fifoPush) begin
      overflow_d = 1'b1;
    end
    if (cmdLoad) begin
      cursor_d = cmdValue;
    end
    if (cmdReject) begin
      cursorError_d = 1'b1;
    end
  end

  // Control state registers: cursor, command FSM, FIFO pointers and flags.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      argLow_q      <= '0;
      argMid_q      <= '0;
      cursor_q      <= '0;
      frameDone_q   <= 1'b0;
      overflow_q    <= 1'b0;
      cursorError_q <= 1'b0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      state_q       <= state_d;
      argLow_q      <= argLow_d;
      argMid_q      <= argMid_d;
      cursor_q      <= cursor_d;
      frameDone_q   <= frameDone_d;
      overflow_q    <= overflow_d;
      cursorError_q <= cursorError_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
    end
  end

  // FIFO storage; entries are cleared on reset so the idle head reads zero.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addrMem_q[i] <= '0;
        dataMem_q[i] <= '0;
      end
    end else if (fifoPush) begin
      addrMem_q[wrPtr_q[PTR_W-1:0]] <= cursor_q;
      dataMem_q[wrPtr_q[PTR_W-1:0]] <= pixel_data;
    end
  end

  assign write_valid   = !fifoEmpty;
  assign write_address = addrMem_q[rdPtr_q[PTR_W-1:0]];
  assign write_data    = dataMem_q[rdPtr_q[PTR_W-1:0]];
  assign frame_done    = frameDone_q;
  assign overflow      = overflow_q;
  assign cursor_error  = cursorError_q;
  assign cursor        = cursor_q;

endmodule

// File: tb/tb_pixel_write_sequencer.sv
// Bench for pixel_write_sequencer: a table of pixel/command vectors with
// expected cursor values, a write scoreboard, and hand-written corner cases.
module tb_pixel_write_sequencer;

  logic        system_clock = 1'b0;
  logic        reset_n;
  logic        pixel_strobe;
  logic [11:0] pixel_data;
  logic        command_strobe;
  logic [7:0]  command_byte;
  logic        write_valid;
  logic        write_ready;
  logic [21:0] write_address;
  logic [11:0] write_data;
  logic        frame_done;
  logic        overflow;
  logic        cursor_error;
  logic [21:0] cursor;

  int checks = 0;
  int failures = 0;
  int popCount = 0;
  int frameDoneCount = 0;

  typedef struct packed {
    logic [21:0] addr;
    logic [11:0] data;
  } wr_t;

  typedef struct {
    logic        pix;
    logic [11:0] data;
    logic        cmd;
    logic [7:0]  cmdByte;
    logic [21:0] expAddr;
    logic [21:0] expCursor;
    logic        expErr;
  } vec_t;

  wr_t  expQ[$];
  wr_t  monEntry;
  vec_t vectors[$];

  pixel_write_sequencer dut (
    .system_clock  (system_clock),
    .reset_n       (reset_n),
    .pixel_strobe  (pixel_strobe),
    .pixel_data    (pixel_data),
    .command_strobe(command_strobe),
    .command_byte  (command_byte),
    .write_valid   (write_valid),
    .write_ready   (write_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .cursor_error  (cursor_error),
    .cursor        (cursor)
  );

  // Free-running 100 MHz clock.
  always #5 system_clock = ~system_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus from just after a rising edge and returns
  // just after the next rising edge with the strobes cleared.
  task automatic applyStimulus(input logic pix, input logic [11:0] data,
                               input logic cmd, input logic [7:0] cmdByte);
    pixel_strobe   = pix;
    pixel_data     = data;
    command_strobe = cmd;
    command_byte   = cmdByte;
    @(posedge system_clock);
    #1;
    pixel_strobe   = 1'b0;
    command_strobe = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 12'h000, 1'b0, 8'h00);
  endtask

  task automatic addVec(input logic pix, input logic [11:0] data, input logic cmd,
                        input logic [7:0] cmdByte, input logic [21:0] expAddr,
                        input logic [21:0] expCursor, input logic expErr);
    vectors.push_back('{pix, data, cmd, cmdByte, expAddr, expCursor, expErr});
  endtask

  // Write monitor: every accepted write is matched against the scoreboard.
  always @(negedge system_clock) begin
    if (reset_n) begin
      if (frame_done) frameDoneCount++;
      if (write_valid && write_ready) begin
        popCount++;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   write_address, write_data);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("write_address", 32'(write_address), 32'(monEntry.addr));
          checkOutput("write_data", 32'(write_data), 32'(monEntry.data));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int snapPops;
    vec_t v;

    reset_n        = 1'b0;
    pixel_strobe   = 1'b0;
    pixel_data     = 12'h000;
    command_strobe = 1'b0;
    command_byte   = 8'h00;
    write_ready    = 1'b1;

    // Main table: pixels, SET_CURSOR (good and bad), wrap, HOME + pixel.
    addVec(1, 12'h00F, 0, 8'h00, 22'd0, 22'd1, 0);
    addVec(1, 12'h0F0, 0, 8'h00, 22'd1, 22'd2, 0);
    addVec(1, 12'hF00, 0, 8'h00, 22'd2, 22'd3, 0);
    addVec(0, 12'h000, 1, 8'h05, 22'd0, 22'd3, 0);
    addVec(0, 12'h000, 1, 8'h2B, 22'd0, 22'd3, 0);
    addVec(0, 12'h000, 1, 8'h01, 22'd0, 22'd3, 0);
    addVec(0, 12'h000, 1, 8'h00, 22'd0, 22'h12B, 0);
    addVec(1, 12'hABC, 0, 8'h00, 22'h12B, 22'h12C, 0);
    addVec(0, 12'h000, 1, 8'h05, 22'd0, 22'h12C, 0);
    addVec(0, 12'h000, 1, 8'hFF, 22'd0, 22'h12C, 0);
    addVec(0, 12'h000, 1, 8'hFF, 22'd0, 22'h12C, 0);
    addVec(0, 12'h000, 1, 8'h04, 22'd0, 22'h12C, 1);
    addVec(1, 12'h123, 0, 8'h00, 22'h12C, 22'h12D, 1);
    addVec(0, 12'h000, 1, 8'h05, 22'd0, 22'h12D, 1);
    addVec(1, 12'h777, 1, 8'hFF, 22'h12D, 22'h12E, 1);
    addVec(0, 12'h000, 1, 8'hAF, 22'd0, 22'h12E, 1);
    addVec(0, 12'h000, 1, 8'h04, 22'd0, 22'd307199, 1);
    addVec(1, 12'h111, 0, 8'h00, 22'd307199, 22'd0, 1);
    addVec(1, 12'h222, 0, 8'h00, 22'd0, 22'd1, 1);
    addVec(0, 12'h000, 1, 8'h05, 22'd0, 22'd1, 1);
    addVec(0, 12'h000, 1, 8'h32, 22'd0, 22'd1, 1);
    addVec(0, 12'h000, 1, 8'h00, 22'd0, 22'd1, 1);
    addVec(0, 12'h000, 1, 8'h00, 22'd0, 22'd50, 1);
    addVec(1, 12'h555, 1, 8'h06, 22'd50, 22'd0, 1);

    // Reset values while reset is held.
    repeat (3) @(posedge system_clock);
    #1;
    checkOutput("reset_cursor", 32'(cursor), 32'd0);
    checkOutput("reset_write_valid", 32'(write_valid), 32'd0);
    checkOutput("reset_write_address", 32'(write_address), 32'd0);
    checkOutput("reset_write_data", 32'(write_data), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_cursor_error", 32'(cursor_error), 32'd0);
    reset_n = 1'b1;
    idleCycles(2);

    for (int i = 0; i < vectors.size(); i++) begin
      v = vectors[i];
      if (v.pix) expQ.push_back({v.expAddr, v.data});
      applyStimulus(v.pix, v.data, v.cmd, v.cmdByte);
      checkOutput($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(v.expCursor));
      checkOutput($sformatf("vec%0d_cursor_error", i), 32'(cursor_error), 32'(v.expErr));
      if (i == 0) checkOutput("first_write_valid", 32'(write_valid), 32'd1);
    end
    idleCycles(3);
    checkOutput("frame_done_pulses", 32'(frameDoneCount), 32'd1);
    checkOutput("table_drained", 32'(expQ.size()), 32'd0);

    // Back-pressure: six pixels into a stalled four-entry FIFO.
    checkOutput("overflow_before", 32'(overflow), 32'd0);
    write_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expQ.push_back({22'(k), 12'hA00 + 12'(k)});
      applyStimulus(1'b1, 12'hA00 + 12'(k), 1'b0, 8'h00);
    end
    checkOutput("stall_cursor", 32'(cursor), 32'd4);
    checkOutput("stall_overflow", 32'(overflow), 32'd1);
    checkOutput("stall_write_valid", 32'(write_valid), 32'd1);
    checkOutput("stall_head_addr", 32'(write_address), 32'd0);
    checkOutput("stall_head_data", 32'(write_data), 32'hA00);
    idleCycles(3);
    checkOutput("hold_head_addr", 32'(write_address), 32'd0);
    checkOutput("hold_head_data", 32'(write_data), 32'hA00);
    snapPops = popCount;
    write_ready = 1'b1;
    idleCycles(8);
    checkOutput("drain_count", 32'(popCount - snapPops), 32'd4);
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_write_valid", 32'(write_valid), 32'd0);

    // Reset in the middle of a SET_CURSOR with a pixel waiting in the FIFO.
    write_ready = 1'b0;
    applyStimulus(1'b1, 12'h0AB, 1'b0, 8'h00);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h05);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h11);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h22);
    reset_n = 1'b0;
    #2;
    checkOutput("midreset_write_valid", 32'(write_valid), 32'd0);
    checkOutput("midreset_cursor", 32'(cursor), 32'd0);
    checkOutput("midreset_overflow", 32'(overflow), 32'd0);
    @(posedge system_clock);
    #1;
    reset_n = 1'b1;
    write_ready = 1'b1;
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h2B);
    checkOutput("after_reset_2B_cursor", 32'(cursor), 32'd0);
    checkOutput("after_reset_2B_error", 32'(cursor_error), 32'd0);
    checkOutput("after_reset_fifo_empty", 32'(write_valid), 32'd0);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h05);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h07);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h00);
    applyStimulus(1'b0, 12'h000, 1'b1, 8'h00);
    checkOutput("after_reset_set_cursor", 32'(cursor), 32'd7);
    expQ.push_back({22'd7, 12'h3C3});
    applyStimulus(1'b1, 12'h3C3, 1'b0, 8'h00);
    checkOutput("after_reset_pixel_cursor", 32'(cursor), 32'd8);
    idleCycles(3);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
